not_gate_checker: RTL
=====================

// Module: not_gate_checker
// PURPOSE
//   Self-checking driver/monitor for a single-input inverter (not_gate) under test.
//   Drives a stimulus sequence onto the gate input, waits a settle time, and samples the gate output.
//   Compares each sample against ~stim and reports the error count and pass/fail.
//   Acts as the synthesizable counterpart of the inverter bench stimulus: it sits beside the inverter in silicon/FPGA.
// PARAMETERS
//   N_VECTORS   6     number of vectors per run (1 .. 2**CNT_W-1)
//   SETTLE_CYC  2     clocks stim is held before the sample cycle (>=1)
//   PATTERN     0     0: alternating 0,1,0,1..; 1: 8-bit LFSR bit 0
//   LFSR_SEED   8'hA5 LFSR seed loaded on each start (nonzero)
//   CNT_W       8     width of counters
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   start         in   1      begin a run; sampled only in IDLE or DONE
//   abort         in   1      return to IDLE from any state; priority over start
//   dut_out       in   1      inverter output (assumed synchronous to clk)
//   stim          out  1      inverter input
//   busy          out  1      high in SETTLE/CHECK
//   done          out  1      high in DONE
//   pass          out  1      done && err_count==0
//   err_count     out  CNT_W  mismatches this run; saturates at all-ones
//   vec_idx       out  CNT_W  index of vector currently applied
//   first_fail    out  CNT_W  index of first mismatch; all-ones if none
// BEHAVIOUR
//   Reset: state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0,
//     first_fail=all-ones, settle cnt=0, lfsr=LFSR_SEED.
//   FSM states: IDLE, SETTLE, CHECK, DONE.
//   IDLE/DONE + start (abort=0):
//     - clear err_count and vec_idx
//     - first_fail=all-ones; lfsr=LFSR_SEED
//     - stim=vector(0), cnt=0 -> SETTLE
//   SETTLE: if cnt==SETTLE_CYC-1 -> CHECK, else cnt++.
//     stim is held stable for exactly SETTLE_CYC clocks.
//   CHECK (one clock): mismatch = (dut_out != ~stim).
//     - On mismatch: err_count++ (saturating); if err_count was 0, first_fail=vec_idx.
//     - If vec_idx==N_VECTORS-1 -> DONE, with stim and vec_idx held.
//     - Else: vec_idx++, stim=vector(vec_idx+1), cnt=0 -> SETTLE.
//   Vector generation:
//     - PATTERN=0: vector(k)=k[0].
//     - PATTERN=1: lfsr advances once per vector (Fibonacci, taps 8,6,5,4, shift left);
//       vector(k)=lfsr[0] after k advances.
//   Timing:
//     - Per-vector latency is SETTLE_CYC+1 clocks.
//     - done rises N_VECTORS*(SETTLE_CYC+1) edges after the edge that sampled start.
//   DONE: outputs hold until start or abort.
//     start in DONE restarts the run; done drops on the same edge.
//   start while busy: ignored.
//   abort: next edge -> IDLE, stim=0, done=0.
//     err_count/vec_idx/first_fail keep their values for debug.
//   abort and start in the same cycle: abort wins.
//   Reset mid-run: immediate return to the reset values above, independent of clk.
// TESTING
//   1. Good inverter (dut_out=~stim registered 0 delay), defaults, start pulse
//      -> stim 0,1,0,1,0,1; done at edge 18; pass=1; err_count=0; first_fail=8'hFF.
//   2. Stuck-at-0 DUT, PATTERN=0
//      -> err_count=3, first_fail=0, pass=0.
//   3. Buffer DUT (dut_out=stim)
//      -> err_count=6, first_fail=0.
//   4. Glitch: invert dut_out only during vector 4
//      -> err_count=1, first_fail=4.
//   5. Control:
//      - abort at edge 7 -> IDLE at edge 8, stim=0, done=0.
//      - start during busy -> ignored.
//      - start in DONE -> restart with counters cleared.
//   6. rst_n low mid-SETTLE (async, between edges) -> all outputs at reset values before next edge.
//      PATTERN=1, seed 8'hA5 -> stim sequence matches a reference LFSR model; pass=1 with good DUT.

Source files
------------

// File: rtl/not_gate_checker.sv
// not_gate_checker: drives vectors into an inverter, samples its output after a settle time, counts mismatches
module not_gate_checker #(
    parameter int         N_VECTORS  = 6,
    parameter int         SETTLE_CYC = 2,
    parameter int         PATTERN    = 0,
    parameter logic [7:0] LFSR_SEED  = 8'hA5,
    parameter int         CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_out,
    output logic             stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_idx,
    output logic [CNT_W-1:0] first_fail
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;
    logic [CNT_W-1:0] idx_nxt;
    logic vec_first;
    logic vec_nxt;
    logic mismatch;
    // next vector: either the parity of the next index or the next lfsr bit 0
    always_comb begin
        lfsr_nxt  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        idx_nxt   = vec_idx + 1'b1;
        vec_first = (PATTERN == 1) ? LFSR_SEED[0] : 1'b0;
        vec_nxt   = (PATTERN == 1) ? lfsr_nxt[0] : idx_nxt[0];
        mismatch  = dut_out != ~stim;
    end
    assign pass = done && (err_count == '0);
    // run control: hold each vector for the settle time, then compare for one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            stim       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            vec_idx    <= '0;
            first_fail <= '1;
            cnt        <= '0;
            lfsr       <= LFSR_SEED;
        end else if (abort) begin
            state <= IDLE;
            stim  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= SETTLE;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    err_count  <= '0;
                    vec_idx    <= '0;
                    first_fail <= '1;
                    lfsr       <= LFSR_SEED;
                    stim       <= vec_first;
                    cnt        <= '0;
                end
                SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) state <= CHECK; else cnt <= cnt + 1'b1;
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (err_count == '0) first_fail <= vec_idx;
                    end
                    if (vec_idx == CNT_W'(N_VECTORS - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= SETTLE;
                        vec_idx <= idx_nxt;
                        stim    <= vec_nxt;
                        lfsr    <= lfsr_nxt;
                        cnt     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
